// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if -- bus handshake signals between the requesting side
// (device interrupt, DMA controller, CPU memory port) and bus_arbiter.
//
//   dev_irq      : device has a block ready              (master -> slave)
//   BR           : bus request from the DMA controller   (master -> slave)
//   cpu_mem_busy : CPU memory access in flight           (master -> slave)
//   BG           : bus grant to the DMA controller       (slave -> master)
//   cmd[31:0]    : DMA command {ADDR, LEN}, 0 = none     (slave -> master)
//   cpu_stall    : CPU must not start a memory access    (slave -> master)
//   done         : one-cycle pulse on transfer complete  (slave -> master)
//   xfer_count   : completed transfers, wraps 255->0     (slave -> master)
//   bus_error    : one-cycle pulse on grant timeout      (slave -> master)
//
// modport master : the requesting side
// modport slave  : the arbiter
interface bus_arbiter_if;
  logic        dev_irq;
  logic        BR;
  logic        cpu_mem_busy;
  logic        BG;
  logic [31:0] cmd;
  logic        cpu_stall;
  logic        done;
  logic [7:0]  xfer_count;
  logic        bus_error;

  modport master (
    output dev_irq, BR, cpu_mem_busy,
    input  BG, cmd, cpu_stall, done, xfer_count, bus_error
  );

  modport slave (
    input  dev_irq, BR, cpu_mem_busy,
    output BG, cmd, cpu_stall, done, xfer_count, bus_error
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter -- CPU/DMA bus arbiter.
//
// A device interrupt makes the arbiter issue a DMA command {DMA_ADDR, DMA_LEN}
// on cmd; the DMA controller answers with BR. The CPU is stalled, and once its
// in-flight memory access has finished the bus is granted (BG) until BR drops.
// Interrupts arriving while busy are remembered (collapsed to one) and served
// on return to IDLE. All outputs are registered.
//
// Ports:
//   CLK     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : bus_arbiter_if.slave (dev_irq, BR, cpu_mem_busy in;
//             BG, cmd, cpu_stall, done, xfer_count, bus_error out)
//
// Parameters:
//   DMA_ADDR : address placed in cmd[31:16]
//   DMA_LEN  : length in words placed in cmd[15:0]
//   TIMEOUT  : maximum number of GRANT cycles (ARB_TIMEOUT_EN only)
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : grants are bounded to TIMEOUT cycles; on expiry BG drops,
//               bus_error pulses and no new grant is given until BR has been
//               seen low.
//   Undefined : grants are unbounded and bus_error is tied to 0.
module bus_arbiter #(
  parameter logic [15:0] DMA_ADDR = 16'h01F4,
  parameter logic [15:0] DMA_LEN  = 16'd12,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input logic           CLK,
  input logic           reset_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t      state;
  logic        bg_q;
  logic [31:0] cmd_q;
  logic        stall_q;
  logic        done_q;
  logic [7:0]  count_q;
  logic        pending;
  logic        grant_blocked;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]  tcnt;
  logic        err_q;
  logic        tmo_block;

  assign grant_blocked = tmo_block;
  assign bus.bus_error = err_q;
`else
  logic        unused_timeout;

  assign grant_blocked  = 1'b0;
  assign bus.bus_error  = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign bus.BG         = bg_q;
  assign bus.cmd        = cmd_q;
  assign bus.cpu_stall  = stall_q;
  assign bus.done       = done_q;
  assign bus.xfer_count = count_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bg_q    <= 1'b0;
      cmd_q   <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      pending <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tcnt      <= '0;
      err_q     <= 1'b0;
      tmo_block <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q <= 1'b0;
      // A timed-out requester must be seen releasing BR before it can win again.
      if (!bus.BR)
        tmo_block <= 1'b0;
`endif

      // Interrupts outside IDLE are remembered; repeats collapse into one.
      if (state != IDLE && bus.dev_irq)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.BR) begin
            // A bus request wins over a new interrupt; the interrupt waits.
            state   <= WAIT_IDLE;
            stall_q <= 1'b1;
            if (bus.dev_irq)
              pending <= 1'b1;
          end else if (bus.dev_irq || pending) begin
            state   <= CMD;
            cmd_q   <= {DMA_ADDR, DMA_LEN};
            pending <= 1'b0;
          end
        end

        CMD: begin
          if (bus.BR) begin
            state   <= WAIT_IDLE;
            cmd_q   <= '0;
            stall_q <= 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (!bus.BR) begin
            // Request withdrawn before grant: abort silently.
            state   <= IDLE;
            stall_q <= 1'b0;
          end else if (!bus.cpu_mem_busy && !grant_blocked) begin
            state <= GRANT;
            bg_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end

        GRANT: begin
          if (!bus.BR) begin
            state   <= RELEASE;
            bg_q    <= 1'b0;
            done_q  <= 1'b1;
            count_q <= count_q + 8'd1;
          end
`ifdef ARB_TIMEOUT_EN
          // tcnt counts completed GRANT cycles; the edge closing cycle
          // number TIMEOUT is the expiry point.
          else if (tcnt + 8'd1 == TIMEOUT) begin
            state     <= RELEASE;
            bg_q      <= 1'b0;
            err_q     <= 1'b1;
            tmo_block <= 1'b1;
            tcnt      <= tcnt + 8'd1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end

        RELEASE: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          bg_q    <= 1'b0;
          cmd_q   <= '0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic CLK;
  logic reset_n;

  bus_arbiter_if bus ();

  bus_arbiter #(
    .DMA_ADDR (16'h01F4),
    .DMA_LEN  (16'd12),
    .TIMEOUT  (8'd8)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [31:0] CMD_WORD = 32'h01F4_000C;

  int unsigned n_checks;
  int unsigned n_fail;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable for checking.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      step();
  endtask

  initial begin
    int unsigned dones;
    int unsigned bg_low;
    int unsigned err_seen;

    n_checks = 0;
    n_fail   = 0;

    reset_n          = 1'b0;
    bus.dev_irq      = 1'b0;
    bus.BR           = 1'b0;
    bus.cpu_mem_busy = 1'b0;

    // Reset state
    #12;
    check("rst_bg",    32'(bus.BG),         32'd0);
    check("rst_cmd",   bus.cmd,             32'd0);
    check("rst_stall", 32'(bus.cpu_stall),  32'd0);
    check("rst_done",  32'(bus.done),       32'd0);
    check("rst_count", 32'(bus.xfer_count), 32'd0);
    check("rst_err",   32'(bus.bus_error),  32'd0);
    @(posedge CLK);
    #1;
    reset_n = 1'b1;

    // Basic transfer
    bus.dev_irq = 1'b1;
    step();
    check("basic_cmd",   bus.cmd,            CMD_WORD);
    check("basic_stall", 32'(bus.cpu_stall), 32'd0);
    bus.dev_irq = 1'b0;
    step();
    check("basic_cmd_hold", bus.cmd, CMD_WORD);
    bus.BR = 1'b1;
    step();
    check("basic_cmd_clr", bus.cmd,            32'd0);
    check("basic_stall_w", 32'(bus.cpu_stall), 32'd1);
    check("basic_bg_w",    32'(bus.BG),        32'd0);
    step();
    check("basic_bg_on", 32'(bus.BG), 32'd1);
    steps(11);
    check("basic_bg_hold", 32'(bus.BG), 32'd1);
    bus.BR = 1'b0;
    step();
    check("basic_bg_off",  32'(bus.BG),         32'd0);
    check("basic_done",    32'(bus.done),       32'd1);
    check("basic_count",   32'(bus.xfer_count), 32'd1);
    check("basic_stall_r", 32'(bus.cpu_stall),  32'd1);
    step();
    check("basic_stall_i", 32'(bus.cpu_stall), 32'd0);
    check("basic_done_lo", 32'(bus.done),      32'd0);

    // CPU busy delays the grant
    bus.cpu_mem_busy = 1'b1;
    bus.BR           = 1'b1;
    step();
    check("busy_bg0", 32'(bus.BG), 32'd0);
    step();
    check("busy_bg1", 32'(bus.BG), 32'd0);
    step();
    check("busy_bg2",    32'(bus.BG),        32'd0);
    check("busy_stall",  32'(bus.cpu_stall), 32'd1);
    bus.cpu_mem_busy = 1'b0;
    step();
    check("busy_bg_on", 32'(bus.BG), 32'd1);
    bus.BR = 1'b0;
    step();
    check("busy_count", 32'(bus.xfer_count), 32'd2);
    step();

    // Pending request: two interrupts during one grant give one command
    bus.BR = 1'b1;
    steps(2);
    check("pend_bg", 32'(bus.BG), 32'd1);
    bus.dev_irq = 1'b1;
    step();
    bus.dev_irq = 1'b0;
    step();
    bus.dev_irq = 1'b1;
    step();
    bus.dev_irq = 1'b0;
    bus.BR      = 1'b0;
    step();
    check("pend_done", 32'(bus.done), 32'd1);
    step();
    check("pend_idle_cmd",   bus.cmd,            32'd0);
    check("pend_idle_stall", 32'(bus.cpu_stall), 32'd0);
    step();
    check("pend_cmd", bus.cmd, CMD_WORD);
    bus.BR = 1'b1;
    step();
    check("pend_cmd_clr", bus.cmd, 32'd0);
    // Withdraw BR in WAIT_IDLE: abort
    bus.BR = 1'b0;
    step();
    check("abort_stall", 32'(bus.cpu_stall), 32'd0);
    check("abort_bg",    32'(bus.BG),        32'd0);
    check("abort_done",  32'(bus.done),      32'd0);
    steps(2);
    check("pend_once",   bus.cmd,             32'd0);
    check("abort_count", 32'(bus.xfer_count), 32'd3);

    // BR and dev_irq together in IDLE: BR first, command afterwards
    bus.BR      = 1'b1;
    bus.dev_irq = 1'b1;
    step();
    check("prio_cmd",   bus.cmd,            32'd0);
    check("prio_stall", 32'(bus.cpu_stall), 32'd1);
    bus.dev_irq = 1'b0;
    step();
    check("prio_bg", 32'(bus.BG), 32'd1);
    bus.BR = 1'b0;
    step();
    check("prio_count", 32'(bus.xfer_count), 32'd4);
    steps(2);
    check("prio_cmd_late", bus.cmd, CMD_WORD);
    bus.BR = 1'b1;
    step();
    bus.BR = 1'b0;
    step();

    // Reset in the middle of a grant
    bus.BR = 1'b1;
    steps(2);
    check("mrst_bg_pre", 32'(bus.BG), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_bg",    32'(bus.BG),         32'd0);
    check("mrst_stall", 32'(bus.cpu_stall),  32'd0);
    check("mrst_cmd",   bus.cmd,             32'd0);
    check("mrst_count", 32'(bus.xfer_count), 32'd0);
    @(negedge CLK);
    bus.BR  = 1'b0;
    reset_n = 1'b1;
    step();
    check("mrst_after_bg", 32'(bus.BG), 32'd0);

    // 256 transfers wrap the counter
    dones = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      bus.BR = 1'b1;
      steps(2);
      bus.BR = 1'b0;
      step();
      if (bus.done)
        dones++;
      step();
      if (i == 127)
        check("wrap_mid", 32'(bus.xfer_count), 32'd128);
    end
    check("wrap_count", 32'(bus.xfer_count), 32'd0);
    check("wrap_dones", dones,               32'd256);

`ifdef ARB_TIMEOUT_EN
    // Grant held too long: BG drops after 8 cycles, bus_error pulses
    bus.BR = 1'b1;
    steps(2);
    check("tmo_bg_on", 32'(bus.BG), 32'd1);
    steps(7);
    check("tmo_bg_last", 32'(bus.BG), 32'd1);
    step();
    check("tmo_bg_off", 32'(bus.BG),         32'd0);
    check("tmo_err",    32'(bus.bus_error),  32'd1);
    check("tmo_done",   32'(bus.done),       32'd0);
    check("tmo_count",  32'(bus.xfer_count), 32'd0);
    step();
    check("tmo_err_lo", 32'(bus.bus_error), 32'd0);
    steps(4);
    check("tmo_blocked", 32'(bus.BG), 32'd0);
    bus.BR = 1'b0;
    step();
    bus.BR = 1'b1;
    steps(2);
    check("tmo_regrant", 32'(bus.BG), 32'd1);
    bus.BR = 1'b0;
    step();
    check("tmo_count2", 32'(bus.xfer_count), 32'd1);
    step();
`else
    // Without the timeout a grant is unbounded and bus_error stays low
    bus.BR = 1'b1;
    steps(2);
    bg_low   = 0;
    err_seen = 0;
    for (int unsigned i = 0; i < 300; i++) begin
      if (!bus.BG)
        bg_low++;
      if (bus.bus_error)
        err_seen++;
      step();
    end
    check("long_bg_low", bg_low,   32'd0);
    check("long_err",    err_seen, 32'd0);
    bus.BR = 1'b0;
    step();
    check("long_done",  32'(bus.done),       32'd1);
    check("long_count", 32'(bus.xfer_count), 32'd1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The module SHALL have parameter DMA_ADDR, default 16'h01F4: memory address loaded into cmd[31:16].
REQ-002 The module SHALL have parameter DMA_LEN, default 16'd12: transfer length in words, loaded into cmd[15:0].
REQ-003 The module SHALL have parameter TIMEOUT, default 8'd255: maximum number of GRANT cycles, used only under ARB_TIMEOUT_EN.
REQ-004 The module SHALL have port CLK: input, 1 bit, system clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 The module SHALL have port dev_irq: input, 1 bit, external device has a block ready.
REQ-007 The module SHALL have port BR: input, 1 bit, bus request from the DMA controller.
REQ-008 The module SHALL have port cpu_mem_busy: input, 1 bit, CPU memory access in flight.
REQ-009 The module SHALL have port BG: output, 1 bit, bus grant to the DMA controller.
REQ-010 The module SHALL have port cmd: output, 32 bits, DMA command {ADDR, LEN}; zero means no command.
REQ-011 The module SHALL have port cpu_stall: output, 1 bit, CPU issues no new memory access while high.
REQ-012 The module SHALL have port done: output, 1 bit, one-cycle pulse on normal transfer completion.
REQ-013 The module SHALL have port xfer_count: output, 8 bits, count of completed transfers, wrapping 255->0.
REQ-014 The module SHALL have port bus_error: output, 1 bit, one-cycle pulse on grant timeout.

Function
REQ-015 All outputs SHALL be registered and the FSM SHALL have states IDLE, CMD, WAIT_IDLE, GRANT and RELEASE.
REQ-016 In IDLE, with dev_irq=1 and BR=0, the FSM SHALL enter CMD and set cmd={DMA_ADDR,DMA_LEN} at that edge.
REQ-017 In CMD, cmd SHALL be held until BR=1 is sampled; at that edge cmd SHALL clear to 0 and the FSM SHALL enter WAIT_IDLE.
REQ-018 In IDLE, BR=1 without a command SHALL go directly to WAIT_IDLE, and this takes priority over a simultaneous dev_irq, which becomes pending.
REQ-019 cpu_stall SHALL be 1 in WAIT_IDLE, GRANT and RELEASE, and 0 in IDLE and CMD.
REQ-020 In WAIT_IDLE, the FSM SHALL enter GRANT and set BG=1 at the first edge where cpu_mem_busy=0, with minimum latency from BR sampled to BG high of 1 cycle.
REQ-021 In GRANT, BG SHALL stay 1 until BR=0 is sampled; at that edge BG SHALL be 0, done SHALL be 1, xfer_count SHALL increment, and the FSM SHALL enter RELEASE.
REQ-022 RELEASE SHALL last exactly one cycle and then return to IDLE; cpu_stall SHALL drop on that transition.
REQ-023 dev_irq asserted in any state other than IDLE SHALL set a pending flag, served as a new request in IDLE; multiple requests SHALL collapse to one.
REQ-024 BR falling in WAIT_IDLE SHALL abort the request: return to IDLE, no BG, no done, no count increment.
REQ-025 xfer_count SHALL wrap modulo 256 with no saturation.

Reset
REQ-026 reset_n=0 SHALL immediately force state=IDLE, BG=0, cmd=0, cpu_stall=0, done=0, bus_error=0, xfer_count=0, pending=0 and timeout counter=0.
REQ-027 A reset during GRANT SHALL drop BG asynchronously, and after release the module SHALL ignore BR until it next samples it in IDLE.

Configuration
REQ-028 With ARB_TIMEOUT_EN defined, an 8-bit counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-029 Under ARB_TIMEOUT_EN, when the counter reaches TIMEOUT with BR=1, the module SHALL drop BG, pulse bus_error, enter RELEASE, and leave done and xfer_count unchanged.
REQ-030 Under ARB_TIMEOUT_EN, after a timeout the module SHALL not re-grant until BR has been sampled 0 at least once.
REQ-031 With ARB_TIMEOUT_EN undefined, bus_error SHALL be constant 0, no counter SHALL exist, and grants SHALL be unbounded.

Verification
REQ-032 Basic transfer: dev_irq pulse in IDLE -> cmd=32'h01F4000C the next cycle; BR=1 -> cmd=0; BG=1 one cycle later; BR=0 after 12 cycles -> BG=0, done=1 pulse, xfer_count=1.
REQ-033 CPU busy: cpu_mem_busy=1 for 3 cycles after BR -> BG stays 0 during those cycles and rises the cycle after cpu_mem_busy falls; cpu_stall=1 throughout.
REQ-034 Pending request: dev_irq during GRANT -> after RELEASE, IDLE lasts 1 cycle, then cmd is reasserted; a second dev_irq in the same GRANT -> only one extra command.
REQ-035 Reset mid-grant: reset_n=0 while BG=1 -> BG, cpu_stall and cmd are 0 immediately and xfer_count=0.
REQ-036 Wrap: 256 completed transfers -> xfer_count=0 and done pulsed 256 times.
REQ-037 Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): BR held high -> BG=0 and bus_error=1 after 8 GRANT cycles; xfer_count unchanged; no re-grant until BR=0 is seen.
